receptor_quadro_serial: RTL and testbench

Serial frame receiver that sits directly upstream of the odd-parity checker stage. It watches a single idle-high serial line and detects a start bit. It samples five data bits, LSB first (E1 = `E[0]` first), then one parity bit, then one stop bit, each at mid-bit. It presents the captured `E[4:0]` and `P` as registered, stable outputs with a one-cycle strobe, ready for direct connection to the parity checker's `E`/`P` inputs.

---
 rtl/receptor_quadro_serial.sv | 160 ++++++++++++++++
 tb/tb_receptor_quadro_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/receptor_quadro_serial.sv
// receptor_quadro_serial: receiver for an idle-high serial frame made of a
// start bit, five data bits sent LSB first, one parity bit and one stop bit.
// Every bit is sampled at mid-bit. The captured data E[4:0] and parity P are
// held on registered outputs until the next good frame, and a one-cycle
// strobe marks each update. P is passed through unchecked; the odd-parity
// checker downstream takes E/P directly.
// Optional macro RX_SINCRONIZADOR_EN: adds a two-flop synchronizer on rx,
// reset to idle (1). This delays all frame timing by two clock edges.
module receptor_quadro_serial #(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [4:0] E,
  output logic       P,
  output logic       quadro_valido,
  output logic       erro_quadro,
  output logic       ocupado
);

  localparam int METADE = CICLOS_POR_BIT / 2;
  localparam int CW     = (CICLOS_POR_BIT > 2) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [CW-1:0] CNT_MEIO = CW'(METADE - 1);
  localparam logic [CW-1:0] CNT_FIM  = CW'(CICLOS_POR_BIT - 1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [4:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [4:0]    e_q, e_d;
  logic          p_q, p_d;
  logic          qv_q, qv_d;
  logic          ee_q, ee_d;
  logic          rx_f;
  logic          no_meio;
  logic          no_fim;

`ifdef RX_SINCRONIZADOR_EN
  logic [1:0] sinc_q, sinc_d;

  // Shift raw rx through the two synchronizer stages.
  always_comb begin
    sinc_d = {sinc_q[0], rx};
  end

  // Synchronizer flops; reset to the idle line level so reset cannot look like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) sinc_q <= 2'b11;
    else        sinc_q <= sinc_d;
  end

  assign rx_f = sinc_q[1];
`else
  assign rx_f = rx;
`endif

  assign no_meio = (cnt_q == CNT_MEIO);
  assign no_fim  = (cnt_q == CNT_FIM);

  // State register plus the datapath registers that follow the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      e_q      <= '0;
      p_q      <= 1'b0;
      qv_q     <= 1'b0;
      ee_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      e_q      <= e_d;
      p_q      <= p_d;
      qv_q     <= qv_d;
      ee_q     <= ee_d;
    end
  end

  // Next-state logic: move one step through the frame at each mid-bit sample point.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (!rx_f) estado_d = INICIO;
      INICIO:   if (no_meio) estado_d = rx_f ? OCIOSO : DADOS;
      DADOS:    if (no_fim && (bit_q == 3'd4)) estado_d = PARIDADE;
      PARIDADE: if (no_fim) estado_d = PARADA;
      PARADA:   if (no_fim) estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  // Counters, shift/parity capture and output update at the sample points.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    par_d = par_q;
    e_d   = e_q;
    p_d   = p_q;
    qv_d  = 1'b0;
    ee_d  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        cnt_d = '0;
        bit_d = '0;
      end
      INICIO: bit_d = '0;
      DADOS: begin
        if (no_fim) begin
          // The first bit received ends up in sh[0] after five right shifts.
          sh_d  = {rx_f, sh_q[4:1]};
          bit_d = bit_q + 3'd1;
          cnt_d = '0;
        end
      end
      PARIDADE: if (no_fim) par_d = rx_f;
      PARADA: begin
        if (no_fim) begin
          if (rx_f) begin
            e_d  = sh_q;
            p_d  = par_q;
            qv_d = 1'b1;
          end else begin
            ee_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
    // Each bit period starts counting from zero when the state changes.
    if (estado_d != estado_q) cnt_d = '0;
  end

  // Output decode: busy whenever a frame is in progress.
  always_comb begin
    ocupado = (estado_q != OCIOSO);
  end

  assign E             = e_q;
  assign P             = p_q;
  assign quadro_valido = qv_q;
  assign erro_quadro   = ee_q;

endmodule

// File: tb/tb_receptor_quadro_serial.sv
// Bench for receptor_quadro_serial: frames are serialised onto rx. For each
// frame the expected result (kind, E/P, strobe cycle) goes into a queue. A
// monitor on the falling edge pops an entry and compares it whenever the DUT
// strobes. Define RX_SINCRONIZADOR_EN to test the synchronized build.
module tb_receptor_quadro_serial;

  localparam int CPB    = 4;
  localparam int METADE = CPB / 2;
`ifdef RX_SINCRONIZADOR_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [4:0] E;
  logic       P;
  logic       qv;
  logic       ee;
  logic       oc;

  typedef struct {
    bit         erro;
    logic [4:0] e;
    logic       p;
    int         ciclo;
  } esp_t;

  esp_t       fila[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [4:0] ult_e    = 5'd0;
  logic       ult_p    = 1'b0;

  receptor_quadro_serial #(.CICLOS_POR_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .E             (E),
    .P             (P),
    .quadro_valido (qv),
    .erro_quadro   (ee),
    .ocupado       (oc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serialise one frame. The reference result is what a correct receiver
  // should produce: good stop -> new E/P; bad stop -> error with old E/P held.
  // With glitch set, every non-sample cycle of the data/parity bits is inverted.
  task automatic send_frame(input logic [4:0] d, input logic par, input logic stop, input bit glitch);
    int         n;
    logic [7:0] bits;
    esp_t       x;
    n    = cyc;
    bits = {stop, par, d, 1'b0};
    if (stop) begin
      ult_e  = d;
      ult_p  = par;
      x.erro = 1'b0;
    end else begin
      x.erro = 1'b1;
    end
    x.e     = ult_e;
    x.p     = ult_p;
    x.ciclo = n + 1 + METADE + 7 * CPB + LAT;
    fila.push_back(x);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < CPB; j++) begin
        if (k == 7 && j > METADE)
          rx = 1'b1;
        else if (glitch && k >= 1 && k <= 6 && j != METADE)
          rx = ~bits[k];
        else
          rx = bits[k];
        tick();
      end
    end
    rx = 1'b1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (fila.size() > 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain_timeout", fila.size(), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    esp_t x;
    if (qv || ee) begin
      if (fila.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got qv=%0b ee=%0b expected none (cycle %0d)", qv, ee, cyc);
      end else begin
        x = fila.pop_front();
        check("kind_erro", ee, x.erro);
        check("kind_valido", qv, !x.erro);
        check("E", E, x.e);
        check("P", P, x.p);
        check("pulse_cycle", cyc, x.ciclo);
        check("ocupado_at_pulse", oc, 0);
      end
    end
  end

  initial begin
    int         ncnt;
    logic [4:0] rd;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    check("rst_E", E, 0);
    check("rst_P", P, 0);
    check("rst_qv", qv, 0);
    check("rst_ee", ee, 0);
    check("rst_ocupado", oc, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Good frame: bits 0,1,1,0,1 then P=0.
    send_frame(5'b10110, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("good_E_const", E, 5'b10110);
    check("good_parity_odd", ^{E, P}, 1);

    // False start: one low cycle from idle.
    rx = 1'b0;
    tick();
    rx   = 1'b1;
    ncnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (oc) ncnt++;
      tick();
    end
    check("false_start_busy_cycles", ncnt, 2);
    check("false_start_E", E, 5'b10110);
    check("false_start_P", P, 0);

    // Bad stop bit after a good frame.
    send_frame(5'b00001, 1'b1, 1'b1, 1'b0);
    send_frame(5'b10101, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("bad_stop_E_held", E, 5'b00001);
    check("bad_stop_P_held", P, 1);

    // Back-to-back frames with no idle gap.
    send_frame(5'b11111, 1'b0, 1'b1, 1'b0);
    send_frame(5'b00000, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Glitches between sample points.
    send_frame(5'b01101, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Reset pulse during data bit 2.
    rd = 5'($urandom);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 2; k++) begin
      rx = rd[k];
      repeat (CPB) tick();
    end
    rx = rd[2];
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_E", E, 0);
    check("midrst_P", P, 0);
    check("midrst_ocupado", oc, 0);
    check("midrst_qv", qv, 0);
    rst_n = 1'b1;
    rx    = 1'b1;
    ult_e = 5'd0;
    ult_p = 1'b0;
    repeat (40) tick();
    check("after_rst_ocupado", oc, 0);
    send_frame(5'b01011, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Random traffic.
    for (int f = 0; f < 30; f++) begin
      send_frame(5'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain();
    repeat (10) tick();
    check("queue_empty_end", fila.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
